// File: rtl/song_recorder.sv
// song_recorder: samples the live channel enables and waveform select once per
// song tick and writes each sample as one W-bit frame into a song RAM.
// Optional build macro: REC_SKIP_SILENCE_EN (skip leading silence after start).
module song_recorder #(
    parameter int NUM_CHANNELS = 25,
    parameter int W            = 96,
    parameter int SONG_LENGTH  = 288,
    parameter int CLK_DIVIDE   = 749999,
    parameter int ADDR_SIZE    = $clog2(SONG_LENGTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    stop,
    input  logic [NUM_CHANNELS-1:0] channel_ena,
    input  logic [1:0]              waveform,
    output logic                    wr_en,
    output logic [ADDR_SIZE-1:0]    wr_addr,
    output logic [W-1:0]            wr_data,
    output logic                    recording,
    output logic                    full,
    output logic [ADDR_SIZE:0]      rec_length
);

    localparam int DIV_W = (CLK_DIVIDE > 0) ? $clog2(CLK_DIVIDE + 1) : 1;
    localparam logic [DIV_W-1:0]     DIV_MAX   = DIV_W'(CLK_DIVIDE);
    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(SONG_LENGTH - 1);
    // Unused low bits of each frame are padding below channel_ena/waveform.
    localparam int PAD = W - NUM_CHANNELS - 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [DIV_W-1:0]       div_q, div_d;
    logic                   wr_en_q, wr_en_d;
    logic [ADDR_SIZE-1:0]   wr_addr_q, wr_addr_d;
    logic [W-1:0]           wr_data_q, wr_data_d;
    logic                   full_q, full_d;
    logic [ADDR_SIZE:0]     rec_len_q, rec_len_d;
`ifdef REC_SKIP_SILENCE_EN
    // High from start until the first nonzero channel_ena is seen.
    logic                   wait_q, wait_d;
`endif
    logic                   tick;
    logic [W-1:0]           frame;

    assign frame = W'({channel_ena, waveform}) << PAD;

    // Next-state, divider, write scheduling and post-write bookkeeping.
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        full_d    = full_q;
        rec_len_d = rec_len_q;
        tick      = 1'b0;
`ifdef REC_SKIP_SILENCE_EN
        wait_d    = wait_q;
`endif

        // The cycle after a write: advance address (saturating) and count it.
        if (wr_en_q) begin
            rec_len_d = rec_len_q + (ADDR_SIZE+1)'(1);
            if (wr_addr_q == LAST_ADDR) begin
                full_d = 1'b1;
            end else begin
                wr_addr_d = wr_addr_q + ADDR_SIZE'(1);
            end
        end

        case (state_q)
            IDLE, DONE: begin
                div_d = '0;
                if (start) begin
                    state_d   = REC;
                    wr_addr_d = '0;
                    rec_len_d = '0;
                    full_d    = 1'b0;
`ifdef REC_SKIP_SILENCE_EN
                    wait_d    = 1'b1;
`endif
                end
            end
            REC: begin
                if (stop) begin
                    // A tick on this cycle is dropped; a write already
                    // registered still goes out this cycle.
                    state_d = DONE;
                    div_d   = '0;
                end else if (wr_en_q && (wr_addr_q == LAST_ADDR)) begin
                    state_d = DONE;
                    div_d   = '0;
                end else begin
`ifdef REC_SKIP_SILENCE_EN
                    if (wait_q) begin
                        div_d = '0;
                        if (channel_ena != '0) begin
                            tick   = 1'b1;
                            wait_d = 1'b0;
                        end
                    end else begin
                        tick  = (div_q == DIV_MAX);
                        div_d = tick ? '0 : div_q + DIV_W'(1);
                    end
`else
                    tick  = (div_q == DIV_MAX);
                    div_d = tick ? '0 : div_q + DIV_W'(1);
`endif
                end
            end
            default: begin
                state_d = IDLE;
                div_d   = '0;
            end
        endcase

        if (tick) begin
            wr_en_d   = 1'b1;
            wr_data_d = frame;
        end
    end

    // State and output registers; reset clears everything, including a
    // write that was scheduled but not yet presented.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            div_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            full_q    <= 1'b0;
            rec_len_q <= '0;
`ifdef REC_SKIP_SILENCE_EN
            wait_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            full_q    <= full_d;
            rec_len_q <= rec_len_d;
`ifdef REC_SKIP_SILENCE_EN
            wait_q    <= wait_d;
`endif
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign full       = full_q;
    assign rec_length = rec_len_q;
    assign recording  = (state_q == REC);

endmodule

// File: tb/tb_song_recorder.sv
// Scoreboard bench for song_recorder: each take's expected RAM writes are
// derived from the tick schedule and pushed into a queue; a negedge monitor
// pops and compares every write the DUT presents.
module tb_song_recorder;

    localparam int NC = 25;
    localparam int W  = 96;
    localparam int SL = 4;
    localparam int CD = 3;
    localparam int AS = 2;
    localparam int L  = 40;   // cycles driven per take

    logic          clk = 1'b0;
    logic          rst;
    logic          start, stop;
    logic [NC-1:0] ena;
    logic [1:0]    wave;
    logic          wr_en, recording, full;
    logic [AS-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic [AS:0]   rec_length;

    typedef struct {
        int            cyc;
        logic [AS-1:0] addr;
        logic [W-1:0]  data;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    song_recorder #(
        .NUM_CHANNELS(NC), .W(W), .SONG_LENGTH(SL), .CLK_DIVIDE(CD)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .channel_ena(ena), .waveform(wave),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .recording(recording), .full(full), .rec_length(rec_length)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] frame_of(input logic [NC-1:0] e, input logic [1:0] w);
        return {e, w, 69'd0};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every presented write must be the next one the model predicted.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual=addr %0d required=no write (cycle %0d)", wr_addr, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("write_cycle", 128'(cyc), 128'(e.cyc));
                chk("write_addr", 128'(wr_addr), 128'(e.addr));
                chk("write_data", 128'(wr_data), 128'(e.data));
            end
        end
    end

    task automatic chk_queue_drained();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL missing_writes actual=%0d pending required=0", q.size());
            q.delete();
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wr_en"}, 128'(wr_en), 128'(0));
        chk({tag, "_wr_addr"}, 128'(wr_addr), 128'(0));
        chk({tag, "_wr_data"}, 128'(wr_data), 128'(0));
        chk({tag, "_recording"}, 128'(recording), 128'(0));
        chk({tag, "_full"}, 128'(full), 128'(0));
        chk({tag, "_rec_length"}, 128'(rec_length), 128'(0));
    endtask

    // One recording take starting with a start pulse at relative cycle 0.
    // stop_at: relative stop cycle (0 = none). stop0: also stop at cycle 0.
    // zlead: cycles 1..zlead carry silent channel_ena.
    // force_j: -1 random extra start inside REC, 0 none, >0 at that cycle.
    // rst_at: >0 asserts reset mid-cycle at that relative cycle.
    task automatic run_take(input bit dir, input int stop_at, input bit stop0,
                            input int zlead, input int force_j, input int rst_at);
        logic [NC-1:0] e_arr[L];
        logic [1:0]    w_arr[L];
        int s, t, cnt, last_w, endc, j, stop_eff, exp_addr;

        for (int i = 0; i < L; i++) begin
            e_arr[i] = dir ? NC'(1) : NC'($urandom);
            if (!dir && $urandom_range(0, 7) == 0) e_arr[i] = '0;
            if (i >= 1 && i <= zlead) e_arr[i] = '0;
            if (i == zlead + 1) e_arr[i] = e_arr[i] | NC'(1);
            w_arr[i] = dir ? 2'd2 : 2'($urandom_range(0, 3));
        end

        @(posedge clk); #1;
        s = cyc;

        // Tick schedule: every CD+1 cycles after entering REC; with silence
        // skipping, the first tick is the first nonzero enable in REC.
        stop_eff = (stop_at > 0) ? stop_at : 1_000_000;
`ifdef REC_SKIP_SILENCE_EN
        t = -1;
        for (int i = 1; i < L; i++) begin
            if (e_arr[i] != '0) begin t = i; break; end
        end
`else
        t = CD + 1;
`endif
        cnt = 0;
        last_w = 0;
        while (t > 0 && t < L - 1 && t < stop_eff && cnt < SL
               && (rst_at == 0 || t + 1 < rst_at)) begin
            q.push_back('{cyc: s + t + 1, addr: AS'(cnt), data: frame_of(e_arr[t], w_arr[t])});
            cnt++;
            last_w = t + 1;
            t += CD + 1;
        end

        // Last relative cycle spent in REC.
        if (cnt < SL) endc = (stop_at > 0) ? stop_at : L;
        else endc = (stop_at > 0 && stop_at < last_w) ? stop_at : last_w;
        if (force_j < 0) j = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, endc)) : 0;
        else j = force_j;

        for (int i = 0; i < L; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            start = (i == 0) || (j > 0 && i == j);
            stop  = (i == 0) ? stop0 : (stop_at > 0 && i == stop_at);
            ena   = e_arr[i];
            wave  = w_arr[i];
            if (i == 2) chk("recording_mid", 128'(recording), 128'(2 <= endc));
            if (rst_at > 0 && i == rst_at) begin
                #2 rst = 1'b1;
                #1 chk_all_zero("async_reset");
                @(posedge clk); #1;
                rst = 1'b0; start = 1'b0; stop = 1'b0;
                repeat (12) @(posedge clk);
                #1 chk_queue_drained();
                chk_all_zero("after_reset");
                return;
            end
        end
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0;
        exp_addr = (cnt < SL - 1) ? cnt : SL - 1;
        chk("end_recording", 128'(recording), 128'(0));
        chk("end_rec_length", 128'(rec_length), 128'(cnt));
        chk("end_full", 128'(full), 128'(cnt == SL));
        chk("end_wr_addr", 128'(wr_addr), 128'(exp_addr));
        chk("end_wr_en", 128'(wr_en), 128'(0));
        chk_queue_drained();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; ena = '0; wave = '0;
        #1 chk_all_zero("reset_state");
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        // Full take with constant enables; then a take stopped at cycle 10.
        run_take(1'b1, 0, 1'b0, 0, 0, 0);
        run_take(1'b1, 10, 1'b0, 0, 0, 0);
        // Reset asserted mid-recording.
        run_take(1'b1, 0, 1'b0, 0, 0, 7);
        // start+stop together from IDLE, then start+stop together inside REC.
        run_take(1'b0, 6, 1'b1, 0, 6, 0);
        // Stop coinciding with a tick, and with a write cycle.
        run_take(1'b0, 8, 1'b0, 0, 0, 0);
        run_take(1'b0, 9, 1'b0, 0, 0, 0);
        // Long leading silence.
        run_take(1'b0, 0, 1'b0, 20, 0, 0);
        run_take(1'b0, 12, 1'b0, 20, 0, 0);
        // Randomized takes back to back.
        for (int k = 0; k < 14; k++) begin
            run_take(1'b0,
                     ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 20)) : 0,
                     1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 8)), -1, 0);
        end

        repeat (4) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #2_000_000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
